// File: rtl/cic_comb_decimator.sv
// cic_comb_decimator: keeps one of every R valid samples and runs it through N wrapping comb stages.
// Define CIC_COMB_PRIME_EN to suppress out_valid for the first N captures after reset.
module cic_comb_decimator #(
   parameter int W = 32,
   parameter int R = 8,
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] in,
   input  logic         in_valid,
   output logic [W-1:0] out,
   output logic         out_valid
);
   localparam int CW = R > 1 ? $clog2(R) : 1;
   logic [CW-1:0] cnt;
   logic [W-1:0]  d [N];
   logic [W-1:0]  x [N+1];
   logic          capture, primed;
   assign capture = in_valid && cnt == CW'(R - 1);
   always_comb begin
      x[0] = in;
      for (int k = 0; k < N; k++) x[k+1] = x[k] - d[k];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         for (int k = 0; k < N; k++) d[k] <= '0;
      end else begin
         out_valid <= capture && primed;
         if (in_valid) cnt <= capture ? '0 : cnt + CW'(1);
         if (capture) begin
            out <= x[N];
            for (int k = 0; k < N; k++) d[k] <= x[k];
         end
      end
   end
`ifdef CIC_COMB_PRIME_EN
   localparam int PW = $clog2(N + 1);
   logic [PW-1:0] prime;
   assign primed = prime == PW'(N);
   always_ff @(posedge clk) begin
      if (reset) prime <= '0;
      else if (capture && !primed) prime <= prime + PW'(1);
   end
`else
   assign primed = 1'b1;
`endif
endmodule

// File: tb/tb_cic_comb_decimator.sv
// tb_cic_comb_decimator: directed table-driven checks of ramp, gap, reset and wrap behaviour.
module tb_cic_comb_decimator;
   logic        clk = 1'b0;
   logic        reset, vld, vld8, va, vb, vc;
   logic [31:0] in, oa, ob;
   logic [7:0]  in8, oc;
   int          checks = 0, errors = 0;
`ifdef CIC_COMB_PRIME_EN
   localparam int PRIME = 1;
`else
   localparam int PRIME = 0;
`endif
   typedef struct {
      logic [31:0] din;
      logic        v;
      int          ord;
      logic [31:0] ea;
      logic [31:0] eb;
   } vec_t;
   vec_t tbl [16];
   int ea_t [16] = '{0, 0, 0, 3, 3, 3, 3, 4, 4, 4, 4, 4, 4, 4, 4, 4};
   int eb_t [16] = '{0, 0, 0, 3, 3, 3, 3, 1, 1, 1, 1, 0, 0, 0, 0, 0};
   int ord_t [16] = '{0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 3, 0, 0, 0, 4};

   always #5 clk = ~clk;

   cic_comb_decimator #(.W(32), .R(4), .N(1)) dut_a (.clk(clk), .reset(reset), .in(in), .in_valid(vld), .out(oa), .out_valid(va));
   cic_comb_decimator #(.W(32), .R(4), .N(2)) dut_b (.clk(clk), .reset(reset), .in(in), .in_valid(vld), .out(ob), .out_valid(vb));
   cic_comb_decimator #(.W(8), .R(1), .N(1)) dut_c (.clk(clk), .reset(reset), .in(in8), .in_valid(vld8), .out(oc), .out_valid(vc));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, act, exp);
      end
   endtask

   // a capture of ordinal ord is strobed unless still priming an n-stage comb
   function automatic logic ev(input int ord, input int n);
      return ord > 0 && ord > PRIME * n;
   endfunction

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset;
      reset = 1'b1; vld = 1'b0; vld8 = 1'b0; in = '0; in8 = '0;
      step;
      step;
      reset = 1'b0;
      chk("rst_oa", oa, 0);
      chk("rst_va", 32'(va), 0);
      chk("rst_ob", ob, 0);
      chk("rst_vb", 32'(vb), 0);
      chk("rst_oc", 32'(oc), 0);
      chk("rst_vc", 32'(vc), 0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) tbl[i] = '{32'(i), 1'b1, ord_t[i], 32'(ea_t[i]), 32'(eb_t[i])};
      reset = 1'b1; vld = 1'b0; vld8 = 1'b0; in = '0; in8 = '0;
      @(negedge clk);
      do_reset;
      for (int i = 0; i < 16; i++) begin
         in = tbl[i].din; vld = tbl[i].v;
         step;
         chk($sformatf("ramp_oa[%0d]", i), oa, tbl[i].ea);
         chk($sformatf("ramp_va[%0d]", i), 32'(va), 32'(ev(tbl[i].ord, 1)));
         chk($sformatf("ramp_ob[%0d]", i), ob, tbl[i].eb);
         chk($sformatf("ramp_vb[%0d]", i), 32'(vb), 32'(ev(tbl[i].ord, 2)));
      end
      do_reset;
      for (int c = 0; c < 24; c++) begin
         vld = (c % 2) == 0;
         in = vld ? tbl[c/2].din : 32'hDEAD;
         step;
         chk($sformatf("gap_oa[%0d]", c), oa, tbl[c/2].ea);
         chk($sformatf("gap_va[%0d]", c), 32'(va), 32'(vld && ev(tbl[c/2].ord, 1)));
         chk($sformatf("gap_ob[%0d]", c), ob, tbl[c/2].eb);
      end
      do_reset;
      for (int i = 0; i < 8; i++) begin
         in = tbl[i].din; vld = 1'b1;
         step;
      end
      chk("mid_pre_oa", oa, 4);
      in = 8; reset = 1'b1;
      step;
      chk("mid_rst_oa", oa, 0);
      chk("mid_rst_va", 32'(va), 0);
      reset = 1'b0;
      for (int j = 0; j < 4; j++) begin
         in = 32'(100 + j);
         step;
         chk($sformatf("mid_oa[%0d]", j), oa, j == 3 ? 103 : 0);
         chk($sformatf("mid_va[%0d]", j), 32'(va), 32'(ev(j == 3 ? 1 : 0, 1)));
      end
      do_reset;
      for (int i = 0; i < 3; i++) begin
         in = tbl[i].din; vld = 1'b1;
         step;
      end
      in = 3; reset = 1'b1;
      step;
      chk("coin_oa", oa, 0);
      chk("coin_va", 32'(va), 0);
      chk("coin_vb", 32'(vb), 0);
      reset = 1'b0;
      for (int j = 0; j < 4; j++) begin
         in = 32'(10 + j);
         step;
         chk($sformatf("coin_oa[%0d]", j), oa, j == 3 ? 13 : 0);
         chk($sformatf("coin_va[%0d]", j), 32'(va), 32'(ev(j == 3 ? 1 : 0, 1)));
         chk($sformatf("coin_ob[%0d]", j), ob, j == 3 ? 13 : 0);
      end
      do_reset;
      in8 = 8'd250; vld8 = 1'b1;
      step;
      chk("wrap_oc0", 32'(oc), 250);
      chk("wrap_vc0", 32'(vc), 32'(ev(1, 1)));
      in8 = 8'd4;
      step;
      chk("wrap_oc1", 32'(oc), 10);
      chk("wrap_vc1", 32'(vc), 32'(ev(2, 1)));
      in8 = 8'd77; vld8 = 1'b0;
      step;
      chk("wrap_hold_oc", 32'(oc), 10);
      chk("wrap_hold_vc", 32'(vc), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
